// File: rtl/oc8051_op_select_nx_pkg.sv
// Shared oc8051 opcode, SFR address and operand-selector FSM encodings.
// The package name oc8051_defines is kept so the rest of the core can import it unchanged.
package oc8051_defines;

  localparam logic [7:0] OC8051_LCALL   = 8'h12;
  localparam logic [7:0] OC8051_MOV_DP  = 8'h90;
  localparam logic [7:0] OC8051_INC_DP  = 8'hA3;
  localparam logic [7:0] OC8051_JMP     = 8'h73;
  localparam logic [7:0] OC8051_MOVC_DP = 8'h93;
  localparam logic [7:0] OC8051_MUL     = 8'hA4;
  localparam logic [7:0] OC8051_DIV     = 8'h84;

  localparam logic [7:0] OC8051_SFR_DPTR_LO = 8'h82;
  localparam logic [7:0] OC8051_SFR_B       = 8'hF0;

  typedef enum logic [1:0] {
    OC8051_OPS_IDLE = 2'd0,
    OC8051_OPS_ARM  = 2'd1,
    OC8051_OPS_INJ  = 2'd2
  } ops_state_t;

endpackage

// File: rtl/oc8051_int_prio_enc.sv
// Fixed-priority encoder: the lowest set request index wins.
module oc8051_int_prio_enc #(
  parameter int NINT = 4,
  parameter int IW   = (NINT > 1) ? $clog2(NINT) : 1
) (
  input  logic [NINT-1:0] i_pend,
  output logic [NINT-1:0] o_win_oh,
  output logic [IW-1:0]   o_win_idx,
  output logic            o_any
);

  // Scanning from the top down lets the lowest index overwrite the result last.
  always_comb begin
    o_win_oh  = '0;
    o_win_idx = '0;
    for (int k = NINT - 1; k >= 0; k--) begin
      if (i_pend[k]) begin
        o_win_oh  = NINT'(1) << k;
        o_win_idx = IW'(k);
      end
    end
  end

  assign o_any = |i_pend;

endmodule

// File: rtl/oc8051_op_select_nx.sv
// Instruction-byte selector with ROM muxing, operand hold and LCALL injection
// to the winning interrupt vector at an instruction boundary.
module oc8051_op_select_nx
  import oc8051_defines::*;
#(
  parameter int            DW       = 8,
  parameter int            NINT     = 4,
  parameter logic [DW-1:0] VEC_HI   = '0,
  parameter logic [DW-1:0] LCALL_OP = DW'(OC8051_LCALL)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NINT-1:0]  intr,
  input  logic [NINT*DW-1:0] int_v,
  input  logic             rd,
  input  logic             ea,
  input  logic             ea_int,
  input  logic [DW-1:0]    op1_i,
  input  logic [DW-1:0]    op2_i,
  input  logic [DW-1:0]    op3_i,
  input  logic [DW-1:0]    op1_x,
  input  logic [DW-1:0]    op2_x,
  input  logic [DW-1:0]    op3_x,
  input  logic             istb,
  input  logic             iack_i,
  input  logic             nop,
  output logic             istb_o,
  output logic [DW-1:0]    op1_out,
  output logic [DW-1:0]    op2_out,
  output logic [DW-1:0]    op3_out,
  output logic [DW-1:0]    op2_direct,
  output logic [NINT-1:0]  ack,
  output logic             int_busy
);

  localparam int IW = (NINT > 1) ? $clog2(NINT) : 1;

  logic            w_sel;
  logic            w_ext_ok;
  logic            w_bnd;
  logic            w_inj;
  logic [DW-1:0]   w_op1, w_op2, w_op3;
  logic [DW-1:0]   w_op1_o, w_op2_o, w_op3_o;
  logic [DW-1:0]   w_dir_in;
  logic [NINT-1:0] w_win_oh;
  logic [IW-1:0]   w_win_idx;
  logic            w_any;
  logic [NINT-1:0] w_clr;

  ops_state_t      r_state;
  logic [NINT-1:0] r_pend;
  logic [NINT-1:0] r_win_oh;
  logic [DW-1:0]   r_vec;
  logic [NINT-1:0] r_ack;
  logic [DW-1:0]   r_op2_h;
  logic [DW-1:0]   r_op3_h;
  logic [DW-1:0]   r_dir_h;

  function automatic logic [DW-1:0] direct_sfr(input logic [DW-1:0] op1,
                                               input logic [DW-1:0] op2);
    logic [DW-1:0] res;
    res = op2;
    if (op1 == DW'(OC8051_MOV_DP) || op1 == DW'(OC8051_INC_DP) ||
        op1 == DW'(OC8051_JMP)    || op1 == DW'(OC8051_MOVC_DP))
      res = DW'(OC8051_SFR_DPTR_LO);
    else if (op1 == DW'(OC8051_MUL) || op1 == DW'(OC8051_DIV))
      res = DW'(OC8051_SFR_B);
    return res;
  endfunction

  oc8051_int_prio_enc #(.NINT(NINT), .IW(IW)) u_prio (
    .i_pend   (r_pend),
    .o_win_oh (w_win_oh),
    .o_win_idx(w_win_idx),
    .o_any    (w_any)
  );

  assign w_sel    = ea & ea_int;
  assign w_ext_ok = nop & iack_i;
  assign istb_o   = (w_sel | rst) ? 1'b0 : istb;

  assign w_op1 = w_sel ? op1_i : (w_ext_ok ? op1_x : '0);
  assign w_op2 = w_sel ? op2_i : (w_ext_ok ? op2_x : '0);
  assign w_op3 = w_sel ? op3_i : (w_ext_ok ? op3_x : '0);

  assign w_bnd = rd & (w_sel | iack_i);
  assign w_inj = (r_state == OC8051_OPS_ARM) & (w_sel | iack_i);

  assign w_op1_o  = w_inj ? LCALL_OP : w_op1;
  assign w_op2_o  = w_inj ? VEC_HI   : w_op2;
  assign w_op3_o  = w_inj ? r_vec    : w_op3;
  assign w_dir_in = direct_sfr(w_op1_o, w_op2_o);

  assign w_clr = (r_state == OC8051_OPS_ARM && w_bnd) ? r_win_oh : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= OC8051_OPS_IDLE;
      r_pend   <= '0;
      r_win_oh <= '0;
      r_vec    <= '0;
      r_ack    <= '0;
    end else begin
      // A new request on the served channel survives its own clear.
      r_pend <= (r_pend & ~w_clr) | intr;
      r_ack  <= '0;
      case (r_state)
        OC8051_OPS_IDLE: begin
          if (w_any) begin
            r_state  <= OC8051_OPS_ARM;
            r_win_oh <= w_win_oh;
            r_vec    <= int_v[w_win_idx*DW +: DW];
          end
        end
        OC8051_OPS_ARM: begin
          if (w_bnd) begin
            r_state <= OC8051_OPS_INJ;
            r_ack   <= r_win_oh;
          end
        end
        OC8051_OPS_INJ: r_state <= OC8051_OPS_IDLE;
        default:        r_state <= OC8051_OPS_IDLE;
      endcase
    end
  end

  // Operand hold stage: capture on every decoder read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op2_h <= '0;
      r_op3_h <= '0;
      r_dir_h <= '0;
    end else if (rd) begin
      r_op2_h <= w_op2_o;
      r_op3_h <= w_op3_o;
      r_dir_h <= w_dir_in;
    end
  end

  assign op1_out    = w_op1_o;
  assign op2_out    = rd ? w_op2_o  : r_op2_h;
  assign op3_out    = rd ? w_op3_o  : r_op3_h;
  assign op2_direct = rd ? w_dir_in : r_dir_h;

  // Reset in the inject cycle suppresses the acknowledge immediately.
  assign ack      = rst ? '0 : r_ack;
  assign int_busy = (r_state != OC8051_OPS_IDLE);

endmodule

// File: tb/tb_oc8051_op_select_nx.sv
// Directed and randomized checks of oc8051_op_select_nx against a cycle-level behavioural model.
module tb_oc8051_op_select_nx;

  localparam int DW   = 8;
  localparam int NINT = 4;

  logic             clk;
  logic             rst;
  logic [NINT-1:0]  intr;
  logic [NINT*DW-1:0] int_v;
  logic             rd, ea, ea_int, istb, iack_i, nop;
  logic [DW-1:0]    op1_i, op2_i, op3_i, op1_x, op2_x, op3_x;
  logic             istb_o;
  logic [DW-1:0]    op1_out, op2_out, op3_out, op2_direct;
  logic [NINT-1:0]  ack;
  logic             int_busy;

  int total = 0;
  int bad   = 0;

  // Model state: phase 0 = idle, 1 = armed, 2 = acknowledging.
  int              m_phase;
  logic [NINT-1:0] m_pend;
  logic [NINT-1:0] m_win_oh;
  logic [DW-1:0]   m_vec;
  logic [DW-1:0]   h2, h3, hd;

  oc8051_op_select_nx dut (
    .clk(clk), .rst(rst), .intr(intr), .int_v(int_v), .rd(rd),
    .ea(ea), .ea_int(ea_int),
    .op1_i(op1_i), .op2_i(op2_i), .op3_i(op3_i),
    .op1_x(op1_x), .op2_x(op2_x), .op3_x(op3_x),
    .istb(istb), .iack_i(iack_i), .nop(nop), .istb_o(istb_o),
    .op1_out(op1_out), .op2_out(op2_out), .op3_out(op3_out),
    .op2_direct(op2_direct), .ack(ack), .int_busy(int_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] dmap(input logic [DW-1:0] o1, input logic [DW-1:0] o2);
    case (o1)
      8'h90, 8'hA3, 8'h73, 8'h93: return 8'h82;
      8'hA4, 8'h84:               return 8'hF0;
      default:                    return o2;
    endcase
  endfunction

  // One clock: check every output at the falling edge, then advance the model at the rising edge.
  task automatic cycle();
    logic s, inj, bnd;
    logic [DW-1:0] r1, r2, r3, e1, e2, e3, ed;
    logic [NINT-1:0] old;
    @(negedge clk);
    s   = ea & ea_int;
    r1  = s ? op1_i : ((nop && iack_i) ? op1_x : 8'h00);
    r2  = s ? op2_i : ((nop && iack_i) ? op2_x : 8'h00);
    r3  = s ? op3_i : ((nop && iack_i) ? op3_x : 8'h00);
    inj = (m_phase == 1) && (s || iack_i);
    e1  = inj ? 8'h12 : r1;
    e2  = inj ? 8'h00 : r2;
    e3  = inj ? m_vec : r3;
    ed  = dmap(e1, e2);
    chk("op1_out", op1_out, e1);
    chk("op2_out", op2_out, rd ? e2 : h2);
    chk("op3_out", op3_out, rd ? e3 : h3);
    chk("op2_direct", op2_direct, rd ? ed : hd);
    chk("ack", ack, (m_phase == 2 && !rst) ? m_win_oh : '0);
    chk("int_busy", int_busy, m_phase != 0);
    chk("istb_o", istb_o, (s || rst) ? 1'b0 : istb);
    @(posedge clk);
    if (rst) begin
      m_phase = 0; m_pend = '0; m_win_oh = '0; m_vec = '0;
      h2 = '0; h3 = '0; hd = '0;
    end else begin
      bnd = rd && (s || iack_i);
      if (rd) begin h2 = e2; h3 = e3; hd = ed; end
      old = m_pend;
      if (m_phase == 1 && bnd) m_pend = m_pend & ~m_win_oh;
      m_pend = m_pend | intr;
      case (m_phase)
        0: if (old != 0) begin
             for (int k = NINT - 1; k >= 0; k--)
               if (old[k]) begin
                 m_win_oh = NINT'(1) << k;
                 m_vec    = int_v[k*DW +: DW];
               end
             m_phase = 1;
           end
        1: if (bnd) m_phase = 2;
        default: m_phase = 0;
      endcase
    end
    #1;
  endtask

  initial begin
    m_phase = 0; m_pend = '0; m_win_oh = '0; m_vec = '0; h2 = '0; h3 = '0; hd = '0;
    rst = 1'b1; intr = 4'hF; int_v = '0; rd = 1'b0; ea = 1'b0; ea_int = 1'b0;
    istb = 1'b0; iack_i = 1'b0; nop = 1'b0;
    op1_i = '0; op2_i = '0; op3_i = '0; op1_x = '0; op2_x = '0; op3_x = '0;
    #1;

    // Reset hold with requests asserted
    cycle(); cycle();
    rst = 1'b0; intr = '0; #1;
    chk("rst_ack", ack, 4'b0000);
    chk("rst_busy", int_busy, 1'b0);
    chk("rst_op2", op2_out, 8'h00);
    repeat (3) cycle();
    chk("rst_no_pend", int_busy, 1'b0);

    // Single channel injection from internal ROM
    ea = 1'b1; ea_int = 1'b1; int_v = 32'h001B0000;
    intr = 4'b0100; cycle();
    intr = '0; cycle();
    rd = 1'b1; #1;
    chk("single_op1", op1_out, 8'h12);
    chk("single_op2", op2_out, 8'h00);
    chk("single_op3", op3_out, 8'h1B);
    cycle();
    rd = 1'b0; #1;
    chk("single_ack", ack, 4'b0100);
    cycle();

    // Priority and frozen arbitration
    int_v = 32'h44332211;
    intr = 4'b1010; cycle();
    intr = '0; cycle();
    rd = 1'b1; #1;
    chk("prio_vec1", op3_out, 8'h22);
    cycle();
    rd = 1'b0; #1;
    chk("prio_ack1", ack, 4'b0010);
    cycle(); cycle();
    chk("prio_rearm", int_busy, 1'b1);
    intr = 4'b0001; cycle();
    intr = '0; rd = 1'b1; #1;
    chk("freeze_vec3", op3_out, 8'h44);
    cycle();
    rd = 1'b0; #1;
    chk("freeze_ack3", ack, 4'b1000);
    cycle(); cycle();
    rd = 1'b1; #1;
    chk("late_vec0", op3_out, 8'h11);
    cycle();
    rd = 1'b0; #1;
    chk("late_ack0", ack, 4'b0001);
    cycle();

    // External fetch path
    ea = 1'b0; istb = 1'b1; nop = 1'b1; iack_i = 1'b0; op1_x = 8'hE5;
    intr = 4'b0100; #1;
    chk("ext_istb", istb_o, 1'b1);
    cycle();
    intr = '0; cycle();
    rd = 1'b1; #1;
    chk("ext_noack_op1", op1_out, 8'h00);
    cycle();
    chk("ext_still_armed", int_busy, 1'b1);
    iack_i = 1'b1; #1;
    chk("ext_inj_op1", op1_out, 8'h12);
    chk("ext_inj_op3", op3_out, 8'h33);
    cycle();
    rd = 1'b0; iack_i = 1'b0; #1;
    chk("ext_ack", ack, 4'b0100);
    cycle();
    ea = 1'b1; #1;
    chk("int_istb_low", istb_o, 1'b0);

    // Operand hold and direct-address mapping
    op1_i = 8'hA4; op2_i = 8'h55; rd = 1'b1; #1;
    chk("dir_b", op2_direct, 8'hF0);
    chk("hold_live", op2_out, 8'h55);
    cycle();
    rd = 1'b0; op2_i = 8'h66; #1;
    chk("hold_op2", op2_out, 8'h55);
    chk("hold_dir", op2_direct, 8'hF0);
    cycle();
    op1_i = 8'h90; rd = 1'b1; #1;
    chk("dir_dpl", op2_direct, 8'h82);
    cycle();
    rd = 1'b0; op1_i = '0;

    // Reset during the inject cycle
    intr = 4'b0010; cycle();
    intr = '0; cycle();
    rd = 1'b1; cycle();
    rd = 1'b0; rst = 1'b1; #1;
    chk("midrst_ack", ack, 4'b0000);
    cycle();
    rst = 1'b0; #1;
    chk("midrst_busy", int_busy, 1'b0);
    chk("midrst_ack_after", ack, 4'b0000);
    repeat (3) cycle();
    chk("midrst_idle", int_busy, 1'b0);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      rst    = ($urandom_range(0, 80) == 0);
      ea     = 1'($urandom);
      ea_int = ($urandom_range(0, 3) != 0);
      intr   = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
      if ($urandom_range(0, 7) == 0) int_v = $urandom;
      rd     = 1'($urandom);
      istb   = 1'($urandom);
      iack_i = 1'($urandom);
      nop    = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       op1_i = 8'h93;
        1:       op1_i = 8'h84;
        default: op1_i = 8'($urandom);
      endcase
      op2_i = 8'($urandom); op3_i = 8'($urandom);
      op1_x = 8'($urandom); op2_x = 8'($urandom); op3_x = 8'($urandom);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
